lzd_seq_ctrl: RTL and testbench
===============================

# lzd_seq_ctrl

Multi-cycle controller that computes the leading-zero count of a WIDTH-bit word using the shared 4-bit leading-zero detector (`LZD_Wrapper`). It scans the word one nibble per cycle, MSB first, and stops at the first non-zero nibble. It sits in front of the normalization path of the systolic-array PE output stage. Operands arrive and results leave on valid/ready handshakes.

## Interface

Parameters:
- `WIDTH`, default 16: operand width. Must be a multiple of 4 and at least 4.
- `NIB`, default WIDTH/4: number of nibbles. Derived; not overridden.
- `CW`, default clog2(WIDTH+1): result count width. Derived; 5 when WIDTH=16.

Ports (one clock; reset is synchronous and active-high):
- `clock` input 1: the single clock. All state updates on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `in_valid` input 1: an operand is offered.
- `in_ready` output 1: the controller can accept an operand.
- `in_data` input WIDTH: the operand.
- `lzd_data` output 4: nibble driven to the LZD `data` input.
- `lzd_zcnt` input 2: LZD `zcnt` result. Combinational from `lzd_data`.
- `lzd_allZero` input 1: LZD `allZero` result. Combinational from `lzd_data`.
- `out_valid` output 1: a result is available.
- `out_ready` input 1: the downstream consumer accepts the result.
- `out_count` output CW: number of leading zeros, 0..WIDTH.
- `out_allZero` output 1: the operand was all zeros.

## Operation

- State machine with three states: IDLE, SCAN, DONE. Registers:
  - `sreg` (WIDTH): operand shift register.
  - `idx`: nibble index, clog2(NIB) bits, minimum 1.
  - `acc` (CW): accumulated zero count.
  - `cnt_q` (CW) and `az_q`: registered results.
- **IDLE**
  - `in_ready`=1.
  - When `in_valid` is sampled high: `sreg`←`in_data`, `idx`←0, `acc`←0, go to SCAN.
- **SCAN**
  - `lzd_data` = `sreg[WIDTH-1:WIDTH-4]`, driven from registers only.
  - If `lzd_allZero`=0: `cnt_q` ← `acc` + zero-extended `lzd_zcnt`, `az_q`←0, go to DONE.
  - Else if `idx`=NIB-1: `cnt_q`←WIDTH, `az_q`←1, go to DONE.
  - Else: `sreg` shifts left by 4 with zero fill, `acc`←`acc`+4, `idx`←`idx`+1, stay in SCAN.
- **DONE**
  - `out_valid`=1.
  - When `out_ready` is sampled high, go to IDLE.
- `out_count`/`out_allZero` are driven from `cnt_q`/`az_q` and are stable while `out_valid`=1.
- `in_ready`=0 in SCAN and DONE. `in_valid` is ignored in those states. An operand is never accepted in the same cycle a result is consumed.
- `lzd_data` is 0 in IDLE and DONE.
- Arithmetic:
  - `acc` never exceeds WIDTH-4, so `acc`+`zcnt` ≤ WIDTH-1 and fits in CW bits.
  - The all-zero result is exactly WIDTH, with `out_allZero`=1 only in that case.
- Trusted LZD contract: for a non-zero nibble, `zcnt` is its leading-zero count (0..3). `zcnt` is ignored when `allZero`=1.

## Timing

- Reset values:
  - state=IDLE; `in_ready`=1; `out_valid`=0.
  - `out_count`=0; `out_allZero`=0; `lzd_data`=0.
  - `sreg`/`acc`/`idx` all 0.
- Reset has priority over all transitions in every state.
  - Reset mid-SCAN or mid-DONE aborts the operation; the result is discarded.
  - The cycle after reset is deasserted behaves as IDLE.
- Latency:
  - Operand accepted at edge T.
  - The first non-zero nibble is index k (0-based), or k=NIB-1 if the operand is all zeros.
  - SCAN occupies k+1 cycles. `out_valid` rises after edge T+k+1.
  - Minimum latency 1 cycle (MSB nibble non-zero). Maximum NIB cycles.
- Result handshake:
  - The result is held indefinitely while `out_ready`=0.
  - Transfer occurs on the edge where `out_valid`&`out_ready`=1. `out_valid` falls and `in_ready` rises on the next cycle.
- Throughput: one operand per (k+1)+1+1 cycles at best. Back-to-back overlap is not supported.

## Test plan

WIDTH=16 throughout.
- Reset, then 0x8000 with `out_ready`=1 → 1 SCAN cycle; `out_count`=0, `out_allZero`=0; `lzd_data` shows 0x8 in SCAN.
- 0x0F00 → 2 SCAN cycles (`lzd_data` 0x0 then 0xF); `out_count`=4, `out_allZero`=0.
- 0x0001 → 4 SCAN cycles; `out_count`=15, `out_allZero`=0. Then 0x0000 → 4 SCAN cycles; `out_count`=16, `out_allZero`=1.
- 0x0200 with `out_ready`=0 for 5 cycles → `out_valid` held high, `out_count`=6 stable; `in_ready`=0 and a second `in_valid` is ignored. Raise `out_ready` → IDLE next cycle, `in_ready`=1.
- 0x0000 accepted, reset asserted on the 2nd SCAN cycle → next cycle: `out_valid`=0, `in_ready`=1, `lzd_data`=0. Then 0x4000 → `out_count`=1 with no stale state carried over.
- Randomized sweep of 1000 operands with random `out_ready` stalls, checked against a reference count → every `out_count`/`out_allZero` matches, and SCAN length equals k+1.

Source files
------------

// File: rtl/lzd_seq_ctrl.sv
// lzd_seq_ctrl: multi-cycle leading-zero counter built around an external
// 4-bit leading-zero detector. The operand is scanned one nibble per cycle,
// MSB first, stopping at the first non-zero nibble.
//
// Handshakes: a transfer happens on a rising clock edge where both valid and
// ready are high. The producer holds valid and its data stable until that
// edge. in_ready is high only in IDLE, and out_valid is high only in DONE.
// Because of this, an operand can never be accepted in the same cycle that a
// result is consumed.
module lzd_seq_ctrl #(
    parameter int WIDTH = 16,
    parameter int NIB   = WIDTH / 4,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [3:0]       lzd_data,
    input  logic [1:0]       lzd_zcnt,
    input  logic             lzd_allZero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_count,
    output logic             out_allZero,
    output logic [1:0]       dbg_state
);

    // The nibble index needs at least one bit, even when there is only one nibble.
    localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             az_q, az_d;

    // State and datapath registers. Reset clears everything, which
    // discards any operation that is still in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            az_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            az_q    <= az_d;
        end
    end

    // Next-state logic and the scan datapath. The LZD is presented only
    // with registered data, so its output has no path back to itself.
    always_comb begin
        state_d  = state_q;
        sreg_d   = sreg_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        az_d     = az_q;
        in_ready = 1'b0;
        lzd_data = 4'h0;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    sreg_d  = in_data;
                    idx_d   = '0;
                    acc_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                lzd_data = sreg_q[WIDTH-1 -: 4];
                if (!lzd_allZero) begin
                    cnt_d   = acc_q + {{(CW-2){1'b0}}, lzd_zcnt};
                    az_d    = 1'b0;
                    state_d = DONE;
                end else if (idx_q == IW'(NIB - 1)) begin
                    // The last nibble is also zero, so the whole word is zero.
                    cnt_d   = CW'(WIDTH);
                    az_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    sreg_d = sreg_q << 4;
                    acc_d  = acc_q + CW'(4);
                    idx_d  = idx_q + IW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign out_valid   = (state_q == DONE);
    assign out_count   = cnt_q;
    assign out_allZero = az_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_lzd_seq_ctrl.sv
// tb_lzd_seq_ctrl: directed and randomized checks of lzd_seq_ctrl (WIDTH=16)
// against a reference leading-zero model. A behavioural LZD closes the
// detector loop. The driver pushes an expected result for every accepted
// operand, and the monitor pops and compares it when the result transfers.
module tb_lzd_seq_ctrl;

    localparam int W = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [3:0]  lzd_data;
    logic [1:0]  lzd_zcnt;
    logic        lzd_allZero;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_count;
    logic        out_allZero;
    logic [1:0]  dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    // expected entry: [11:8] scan cycles, [5] all-zero flag, [4:0] count
    logic [W-1:0] exp_q[$];

    lzd_seq_ctrl #(.WIDTH(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .lzd_data   (lzd_data),
        .lzd_zcnt   (lzd_zcnt),
        .lzd_allZero(lzd_allZero),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_count  (out_count),
        .out_allZero(out_allZero),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    always #5 clock = ~clock;

    // behavioural 4-bit leading-zero detector
    always_comb begin
        lzd_allZero = (lzd_data == 4'h0);
        casez (lzd_data)
            4'b1???: lzd_zcnt = 2'd0;
            4'b01??: lzd_zcnt = 2'd1;
            4'b001?: lzd_zcnt = 2'd2;
            default: lzd_zcnt = 2'd3;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [15:0] d);
        int lz;
        bit found;
        int klen;
        logic az;
        lz = 0;
        found = 0;
        for (int i = 15; i >= 0; i--) begin
            if (!found) begin
                if (d[i]) found = 1;
                else lz++;
            end
        end
        az = (d == 16'h0);
        klen = az ? 4 : (lz / 4) + 1;
        return {4'h0, 4'(klen), 2'b00, az, 5'(lz)};
    endfunction

    // driver tasks: inputs change at posedge+1, handshakes are sampled at negedge
    task automatic send(input logic [15:0] d);
        in_valid = 1'b1;
        in_data  = d;
        for (int c = 0; c < 50; c++) begin
            @(negedge clock);
            if (in_ready) begin
                exp_q.push_back(model(d));
                @(posedge clock);
                #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
        check("send_timeout", 0, 1);
    endtask

    task automatic drain(input bit rand_stall);
        for (int c = 0; c < 200; c++) begin
            out_ready = rand_stall ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clock);
            if (out_valid && out_ready) begin
                @(posedge clock);
                #1;
                out_ready = 1'b0;
                return;
            end
            @(posedge clock);
            #1;
        end
        check("drain_timeout", 0, 1);
    endtask

    // scoreboard monitor
    int scan_cnt = 0;
    bit seen_valid = 0;
    always @(negedge clock) begin
        if (reset) begin
            scan_cnt   = 0;
            seen_valid = 0;
        end else begin
            if (!in_ready && !out_valid) scan_cnt++;
            if (in_ready || out_valid) check("lzd_data_idle", 32'(lzd_data), 0);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    if (!seen_valid) begin
                        check("scan_len", scan_cnt, 32'(exp_q[0][11:8]));
                        seen_valid = 1;
                    end
                    check("out_count", 32'(out_count), 32'(exp_q[0][4:0]));
                    check("out_allZero", 32'(out_allZero), 32'(exp_q[0][5]));
                    check("in_ready_done", 32'(in_ready), 0);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        scan_cnt   = 0;
                        seen_valid = 0;
                    end
                end
            end
        end
    end

    initial begin
        logic [15:0] d;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        // reset state
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_count", 32'(out_count), 0);
        check("rst_out_allZero", 32'(out_allZero), 0);
        check("rst_lzd_data", 32'(lzd_data), 0);

        // MSB nibble non-zero: single scan cycle
        out_ready = 1'b1;
        send(16'h8000);
        check("lzd_8000", 32'(lzd_data), 32'h8);
        drain(0);

        // two scan cycles
        send(16'h0F00);
        check("lzd_0f00_a", 32'(lzd_data), 32'h0);
        @(posedge clock);
        #1;
        check("lzd_0f00_b", 32'(lzd_data), 32'hF);
        drain(0);

        // last-nibble and all-zero boundaries
        send(16'h0001);
        drain(0);
        send(16'h0000);
        drain(0);

        // downstream stall, ignored operand offered during DONE
        out_ready = 1'b0;
        send(16'h0200);
        for (int c = 0; c < 20 && !out_valid; c++) begin
            @(posedge clock);
            #1;
        end
        check("stall_reach_done", 32'(out_valid), 1);
        in_valid = 1'b1;
        in_data  = 16'hFFFF;
        for (int c = 0; c < 5; c++) begin
            @(posedge clock);
            #1;
            check("stall_valid", 32'(out_valid), 1);
            check("stall_count", 32'(out_count), 6);
            check("stall_in_ready", 32'(in_ready), 0);
        end
        in_valid = 1'b0;
        drain(0);
        check("post_xfer_in_ready", 32'(in_ready), 1);
        check("post_xfer_out_valid", 32'(out_valid), 0);
        check("sb_empty_stall", exp_q.size(), 0);

        // reset during the second scan cycle aborts the operation
        send(16'h0000);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        exp_q.delete();
        check("abort_out_valid", 32'(out_valid), 0);
        check("abort_in_ready", 32'(in_ready), 1);
        check("abort_lzd_data", 32'(lzd_data), 0);
        send(16'h4000);
        drain(0);

        // randomized sweep with random downstream stalls
        for (int n = 0; n < 1000; n++) begin
            d = 16'($urandom_range(0, 65535)) >> $urandom_range(0, 16);
            send(d);
            drain(1);
        end

        check("sb_empty_final", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
